// File: rtl/fir_pkg.sv
// Shared coefficient format for fir_filter and its coefficient controller:
// default sizes, power-on tap set and controller FSM states.
package fir_pkg;

    localparam int NTAPS_DEFAULT = 4;
    localparam int CW_DEFAULT    = 8;

    localparam logic signed [CW_DEFAULT-1:0] DEFAULT_COEF [NTAPS_DEFAULT] = '{8'sd1, 8'sd2, 8'sd2, 8'sd1};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } coef_state_e;

    // Taps beyond the default table come up as zero when NTAPS is overridden.
    function automatic logic signed [CW_DEFAULT-1:0] default_coef(input int idx);
        default_coef = (idx < NTAPS_DEFAULT) ? DEFAULT_COEF[idx] : '0;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NTAPS x CW coefficient register bank: single write port, whole-bank
// parallel load and synchronous reset to the default tap set.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CW-1:0]         wr_data,
    input  logic                  load_en,
    input  logic [NTAPS*CW-1:0]   load_data,
    output logic [NTAPS*CW-1:0]   coef_flat
);

    logic [CW-1:0] taps_q [NTAPS];

    // A bank load replaces every tap, so it takes precedence over a single write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps_q[i] <= CW'(default_coef(i));
            end
        end else if (load_en) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps_q[i] <= load_data[i*CW +: CW];
            end
        end else if (wr_en) begin
            taps_q[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_flat
        assign coef_flat[g*CW +: CW] = taps_q[g];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Double-buffered FIR coefficient controller: host loads a shadow bank, which
// is swapped into the active bank on a sample boundary. Optional readback port
// is enabled with `define FIR_COEF_READBACK_EN.
module fir_coef_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [CW-1:0]         cfg_data,
    input  logic                  cfg_last,
    input  logic                  cfg_abort,
    output logic [NTAPS*CW-1:0]   coef_out,
    output logic                  busy,
    output logic                  swap_done
`ifdef FIR_COEF_READBACK_EN
    ,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_sel,
    output logic [CW-1:0]         rd_data
`endif
);

    coef_state_e         state_q, state_d;
    logic                swap_done_q;
    logic                beat_accept;
    logic                do_swap;
    logic [NTAPS*CW-1:0] active_flat;
    logic [NTAPS*CW-1:0] shadow_flat;

    // Abort wins over both a pending beat and a swap in the same cycle.
    always_comb begin
        cfg_ready   = (state_q != ARMED);
        beat_accept = cfg_valid && cfg_ready && !cfg_abort;
        do_swap     = (state_q == ARMED) && sample_tick && !cfg_abort;
        state_d     = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (beat_accept) begin
                    state_d = cfg_last ? ARMED : LOAD;
                end
            end
            ARMED: begin
                if (sample_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cfg_abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_done_q <= do_swap;
        end
    end

    fir_coef_bank #(.NTAPS(NTAPS), .CW(CW)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (beat_accept),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_data),
        .load_en   (cfg_abort),
        .load_data (active_flat),
        .coef_flat (shadow_flat)
    );

    fir_coef_bank #(.NTAPS(NTAPS), .CW(CW)) u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .load_en   (do_swap),
        .load_data (shadow_flat),
        .coef_flat (active_flat)
    );

    assign coef_out  = active_flat;
    assign busy      = (state_q != IDLE);
    assign swap_done = swap_done_q;

`ifdef FIR_COEF_READBACK_EN
    logic [CW-1:0]       rd_data_q;
    logic [NTAPS*CW-1:0] rd_bank;

    assign rd_bank = rd_sel ? shadow_flat : active_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_bank[rd_addr*CW +: CW];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed self-checking bench for fir_coef_ctrl (readback port exercised
// when FIR_COEF_READBACK_EN is defined).
module tb_fir_coef_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_last;
    logic        cfg_abort;
    logic [31:0] coef_out;
    logic        busy;
    logic        swap_done;
`ifdef FIR_COEF_READBACK_EN
    logic [1:0]  rd_addr;
    logic        rd_sel;
    logic [7:0]  rd_data;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    fir_coef_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .cfg_abort   (cfg_abort),
        .coef_out    (coef_out),
        .busy        (busy),
        .swap_done   (swap_done)
`ifdef FIR_COEF_READBACK_EN
        ,
        .rd_addr     (rd_addr),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data)
`endif
    );

    // Inputs change 1 time unit after a rising edge so checks never race the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        sample_tick = 1'b0;
        cfg_valid   = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        cfg_last    = 1'b0;
        cfg_abort   = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic sendBeat(input logic [1:0] addr, input logic [7:0] data,
                            input logic last, input logic tick);
        cfg_valid   = 1'b1;
        cfg_addr    = addr;
        cfg_data    = data;
        cfg_last    = last;
        sample_tick = tick;
        step();
        idleInputs();
    endtask

    task automatic pulseTick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        int swapSeen;
        doReset();
        testsRun++;
        if (coef_out !== 32'h01020201) begin
            testsFailed++;
            $display("[TB] FAIL reset_coef: got %h expected %h", coef_out, 32'h01020201);
        end
        testsRun++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: ready=%b busy=%b expected ready=1 busy=0", cfg_ready, busy);
        end
        swapSeen = 0;
        for (int i = 0; i < 20; i++) begin
            if (swap_done !== 1'b0) swapSeen++;
            step();
        end
        testsRun++;
        if (swapSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_swap_quiet: swap_done high %0d cycles expected 0", swapSeen);
        end
    endtask

    task automatic test_full_load();
        sendBeat(2'd0, 8'hFD, 1'b0, 1'b0);
        sendBeat(2'd1, 8'h05, 1'b0, 1'b0);
        testsRun++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL load_state: busy=%b ready=%b expected busy=1 ready=1", busy, cfg_ready);
        end
        sendBeat(2'd2, 8'h07, 1'b0, 1'b0);
        sendBeat(2'd3, 8'hFF, 1'b1, 1'b0);
        testsRun++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL armed_state: ready=%b busy=%b expected ready=0 busy=1", cfg_ready, busy);
        end
        step();
        step();
        testsRun++;
        if (coef_out !== 32'h01020201) begin
            testsFailed++;
            $display("[TB] FAIL armed_hold: got %h expected %h", coef_out, 32'h01020201);
        end
        pulseTick();
        testsRun++;
        if (coef_out !== 32'hFF0705FD) begin
            testsFailed++;
            $display("[TB] FAIL full_swap: got %h expected %h", coef_out, 32'hFF0705FD);
        end
        testsRun++;
        if (swap_done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL swap_flags: swap_done=%b busy=%b ready=%b expected 1 0 1", swap_done, busy, cfg_ready);
        end
        step();
        testsRun++;
        if (swap_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL swap_pulse_width: got %b expected 0", swap_done);
        end
    endtask

    task automatic test_last_with_tick();
        sendBeat(2'd1, 8'h04, 1'b1, 1'b1);
        testsRun++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || swap_done !== 1'b0 || coef_out !== 32'hFF0705FD) begin
            testsFailed++;
            $display("[TB] FAIL last_tick_no_swap: busy=%b ready=%b swap=%b coef=%h expected 1 0 0 %h",
                     busy, cfg_ready, swap_done, coef_out, 32'hFF0705FD);
        end
        for (int i = 0; i < 4; i++) step();
        testsRun++;
        if (coef_out !== 32'hFF0705FD) begin
            testsFailed++;
            $display("[TB] FAIL last_tick_wait: got %h expected %h", coef_out, 32'hFF0705FD);
        end
        pulseTick();
        testsRun++;
        if (coef_out !== 32'hFF0704FD || swap_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL last_tick_swap: coef=%h swap=%b expected %h 1", coef_out, swap_done, 32'hFF0704FD);
        end
    endtask

    task automatic test_partial();
        doReset();
        sendBeat(2'd2, 8'h09, 1'b1, 1'b0);
        step();
        pulseTick();
        testsRun++;
        if (coef_out !== 32'h01090201) begin
            testsFailed++;
            $display("[TB] FAIL partial_load: got %h expected %h", coef_out, 32'h01090201);
        end
    endtask

    task automatic test_abort_armed();
        sendBeat(2'd0, 8'h05, 1'b1, 1'b0);
        cfg_abort   = 1'b1;
        sample_tick = 1'b1;
        step();
        idleInputs();
        testsRun++;
        if (coef_out !== 32'h01090201 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_armed: coef=%h busy=%b ready=%b expected %h 0 1",
                     coef_out, busy, cfg_ready, 32'h01090201);
        end
        step();
        testsRun++;
        if (swap_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_pulse: got %b expected 0", swap_done);
        end
        // Rewriting tap 3 with its current value: tap 0 must come back as 1, not the aborted 5.
        sendBeat(2'd3, 8'h01, 1'b1, 1'b0);
        pulseTick();
        testsRun++;
        if (coef_out !== 32'h01090201) begin
            testsFailed++;
            $display("[TB] FAIL abort_then_commit: got %h expected %h", coef_out, 32'h01090201);
        end
    endtask

    task automatic test_reset_mid_load();
        sendBeat(2'd0, 8'h07, 1'b0, 1'b0);
        sendBeat(2'd1, 8'h07, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        testsRun++;
        if (coef_out !== 32'h01020201 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_load: coef=%h busy=%b ready=%b expected %h 0 1",
                     coef_out, busy, cfg_ready, 32'h01020201);
        end
`ifdef FIR_COEF_READBACK_EN
        rd_sel  = 1'b1;
        rd_addr = 2'd0;
        step();
        testsRun++;
        if (rd_data !== 8'h01) begin
            testsFailed++;
            $display("[TB] FAIL readback_shadow_tap0: got %h expected %h", rd_data, 8'h01);
        end
        rd_sel  = 1'b0;
        rd_addr = 2'd2;
        step();
        testsRun++;
        if (rd_data !== 8'h02) begin
            testsFailed++;
            $display("[TB] FAIL readback_active_tap2: got %h expected %h", rd_data, 8'h02);
        end
`endif
        sendBeat(2'd3, 8'h10, 1'b1, 1'b0);
        pulseTick();
        testsRun++;
        if (coef_out !== 32'h10020201) begin
            testsFailed++;
            $display("[TB] FAIL reset_dropped_load: got %h expected %h", coef_out, 32'h10020201);
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
`ifdef FIR_COEF_READBACK_EN
        rd_addr = '0;
        rd_sel  = 1'b0;
`endif
        test_reset();
        test_full_load();
        test_last_with_tick();
        test_partial();
        test_abort_armed();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Coefficient configuration controller for the `fir_filter` datapath. It accepts coefficient writes from a host over a valid/ready stream into a shadow bank. On a commit, it swaps the shadow bank into the active bank exactly at a sample boundary. The FIR therefore never processes a sample with a half-updated tap set. It sits between the host register interface and `fir_filter`, and drives the filter's coefficient bus.

## Interface
- `NTAPS`, 4, number of FIR taps (power of two, ≥2)
- `CW`, 8, signed coefficient width
- `AW`, `$clog2(NTAPS)`, tap address width (derived, not overridden)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_tick`  in  1  one-cycle strobe; the FIR accepts a new `x_in` on the next edge
- `cfg_valid`  in  1  host write beat valid
- `cfg_ready`  out  1  controller can accept a beat
- `cfg_addr`  in  AW  tap index
- `cfg_data`  in  CW  signed coefficient
- `cfg_last`  in  1  final beat of a load; arms the commit
- `cfg_abort`  in  1  discard pending load, return to IDLE
- `coef_out`  out  NTAPS*CW  active bank, tap 0 in LSBs
- `busy`  out  1  state ≠ IDLE
- `swap_done`  out  1  one-cycle pulse on the cycle after the active bank updates

## Operation
- Beat accepted when `cfg_valid && cfg_ready`. The accepted beat writes `shadow[cfg_addr] <= cfg_data`.
- FSM states:
  - IDLE: `cfg_ready=1`. An accepted beat goes to LOAD, or to ARMED if `cfg_last` is set on that beat.
  - LOAD: `cfg_ready=1`. An accepted beat with `cfg_last` goes to ARMED.
  - ARMED: `cfg_ready=0`. On `sample_tick=1`, `active <= shadow` and the FSM goes to IDLE.
- Partial loads are legal: unwritten shadow taps keep their prior value.
- `cfg_abort`, in any state:
  - `shadow <= active` and the FSM goes to IDLE.
  - A beat presented in the same cycle is not written.
  - Abort has priority over swap.
- `cfg_last` accepted in the same cycle as `sample_tick`: the FSM enters ARMED, and the swap waits for the next tick. There is no same-cycle swap.
- `sample_tick` in IDLE or LOAD: no effect.
- `coef_out` changes only on a swap edge or on reset.

## Timing
- Reset, both banks and all outputs:
  - `active = shadow = DEFAULT_COEF` (1, 2, 2, 1 for tap 0 to 3).
  - FSM in IDLE.
  - `cfg_ready=1`, `busy=0`, `swap_done=0`.
- Reset mid-load or while ARMED drops the pending load. The bank returns to defaults on the next edge.
- Write latency: the shadow register updates on the edge that accepts the beat.
- Swap latency:
  - `coef_out` reflects the new bank on the edge where `sample_tick=1` in ARMED.
  - The sample the FIR accepts after that tick uses the new coefficients.
  - `swap_done` is asserted for the following cycle only.
- `busy` is registered from state. It deasserts in the cycle after the swap.
- No arithmetic. Coefficients pass through unmodified. The width is exactly `CW`, with no extension.

## Configuration
- `FIR_COEF_READBACK_EN` defined:
  - Adds the ports `rd_addr` (in, `AW`), `rd_sel` (in, 1: 0 = active, 1 = shadow) and `rd_data` (out, `CW`).
  - `rd_data` is registered, with 1-cycle latency, and resets to 0.
- `FIR_COEF_READBACK_EN` undefined: these ports and the read register are absent. All other behaviour is identical.

## Structure
- Package `fir_pkg` holds:
  - `CW` and `NTAPS` defaults.
  - The `DEFAULT_COEF` constant array.
  - The FSM state enum (IDLE, LOAD, ARMED).
- The package is shared with `fir_filter`, so both agree on the coefficient format.
- One sub-module, `fir_coef_bank`:
  - NTAPS×CW register array with one write port, a parallel load-from-other-bank port, a sync reset-to-default, and a flattened output.
  - Instantiated twice, once for active and once for shadow.

## Test plan
- Reset release: `coef_out` = {1, 2, 2, 1}, `cfg_ready=1`, `busy=0`, and `swap_done` stays 0 for 20 cycles.
- Load 4 beats, taps {-3, 5, 7, -1}, last beat with `cfg_last`. `cfg_ready` drops. `coef_out` is unchanged until `sample_tick`, then updates on that edge. `swap_done` pulses one cycle later.
- `cfg_last` accepted in the same cycle as `sample_tick`: no swap. The next tick, 5 cycles later, performs the swap.
- Partial load writing only tap 2 = 9, then commit: `coef_out` = {1, 2, 9, 1}.
- Abort while ARMED, with `sample_tick` in the same cycle: no swap, FSM returns to IDLE, and a later commit of an empty load leaves `coef_out` at its previous value.
- `rst` asserted while in LOAD after 2 beats: the next cycle shows defaults, IDLE and `cfg_ready=1`. With `FIR_COEF_READBACK_EN`, a read of shadow tap 0 returns 1.
